fir_mac_array: RTL and testbench

- Parametrised successor of the 4-lane, 40-tap FIR datapath.
- Generalised in input width, coefficient width, lane count and taps per lane.
- Coefficient storage, delay line, time-multiplexed MAC lanes, lane summation and output scaling are integrated behind one sample strobe.
- Adds busy/valid handshake, drop flags, runtime tap count and an optional saturating output stage. Sits between the sample-rate input and the waveform/output path.

---
 rtl/fir_mac_array_if.sv | 32 +++
 rtl/fir_mac_array.sv | 190 +++++++++++++++++++
 tb/tb_fir_mac_array.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_array_if.sv
// Sample/coefficient/result bus for fir_mac_array.
interface fir_mac_array_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NTAP   = 40,
  parameter int unsigned OUT_W  = 16
);
  localparam int unsigned AW = $clog2(NTAP);
  localparam int unsigned NW = AW + 1;

  logic                     iEnSample;
  logic signed [DATA_W-1:0] iFirIn;
  logic [NW-1:0]            iNumOfCoeff;
  logic                     iCoeffWr;
  logic [AW-1:0]            iCoeffAddr;
  logic signed [COEF_W-1:0] iCoeffData;
  logic                     oBusy;
  logic                     oValid;
  logic signed [OUT_W-1:0]  oFirOut;
  logic                     oSampleDrop;
  logic                     oWrDrop;

  modport master (
    output iEnSample, iFirIn, iNumOfCoeff, iCoeffWr, iCoeffAddr, iCoeffData,
    input  oBusy, oValid, oFirOut, oSampleDrop, oWrDrop
  );

  modport slave (
    input  iEnSample, iFirIn, iNumOfCoeff, iCoeffWr, iCoeffAddr, iCoeffData,
    output oBusy, oValid, oFirOut, oSampleDrop, oWrDrop
  );
endinterface

// File: rtl/fir_mac_array.sv
// fir_mac_array: multi-lane time-multiplexed FIR with coefficient store,
// delay line, lane summation and output narrowing behind one sample strobe.
// Optional macro FIR_MAC_ARRAY_SAT_EN: saturating output narrowing
// (undefined: keep low OUT_W bits).
module fir_mac_array #(
  parameter int unsigned DATA_W        = 3,
  parameter int unsigned COEF_W        = 16,
  parameter int unsigned NUM_LANE      = 4,
  parameter int unsigned TAPS_PER_LANE = 10,
  parameter int unsigned ACC_W         = 25,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned OUT_SHIFT     = 0
) (
  input  logic           iClk12M,
  input  logic           iRst,
  fir_mac_array_if.slave bus
);
  localparam int unsigned NTAP     = NUM_LANE * TAPS_PER_LANE;
  localparam int unsigned AW       = $clog2(NTAP);
  localparam int unsigned NW       = AW + 1;
  localparam int unsigned PROD_W   = DATA_W + COEF_W;
  localparam int unsigned LAST_CNT = TAPS_PER_LANE + 2;
  localparam int unsigned CNT_W    = $clog2(LAST_CNT + 1);
`ifdef FIR_MAC_ARRAY_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SUM, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NW-1:0]            n_q, n_d;
  logic signed [COEF_W-1:0] coef_q [NUM_LANE][TAPS_PER_LANE];
  logic signed [COEF_W-1:0] coef_d [NUM_LANE][TAPS_PER_LANE];
  logic signed [DATA_W-1:0] dly_q [NTAP];
  logic signed [DATA_W-1:0] dly_d [NTAP];
  logic signed [COEF_W-1:0] sel_coef_q [NUM_LANE];
  logic signed [COEF_W-1:0] sel_coef_d [NUM_LANE];
  logic signed [DATA_W-1:0] sel_dat_q [NUM_LANE];
  logic signed [DATA_W-1:0] sel_dat_d [NUM_LANE];
  logic signed [PROD_W-1:0] prod_q [NUM_LANE];
  logic signed [PROD_W-1:0] prod_d [NUM_LANE];
  logic signed [ACC_W-1:0]  acc_q [NUM_LANE];
  logic signed [ACC_W-1:0]  acc_d [NUM_LANE];
  logic                     busy_q, busy_d, valid_q, valid_d;
  logic                     sdrop_q, sdrop_d, wdrop_q, wdrop_d;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     accept, wr_ok;
  logic signed [ACC_W-1:0]  sum_c, shift_c;
  logic signed [OUT_W-1:0]  narrow_c;

  // Sign-extending signed multiply into the product width.
  function automatic logic signed [PROD_W-1:0] mul_ext(input logic signed [COEF_W-1:0] c,
                                                       input logic signed [DATA_W-1:0] d);
    logic signed [PROD_W-1:0] ce, de;
    ce = PROD_W'(c);
    de = PROD_W'(d);
    return ce * de;
  endfunction

  // Control FSM: sequencing, tap-count latch, handshake and drop flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    accept  = 1'b0;
    valid_d = 1'b0;
    out_d   = out_q;
    sdrop_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iEnSample) begin
          accept  = 1'b1;
          state_d = S_MAC;
          cnt_d   = '0;
          n_d     = (bus.iNumOfCoeff > NW'(NTAP)) ? NW'(NTAP) : bus.iNumOfCoeff;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_CNT)) state_d = S_SUM;
      end
      S_SUM: begin
        state_d = S_OUT;
        valid_d = 1'b1;
        out_d   = narrow_c;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.iEnSample && (state_q != S_IDLE)) sdrop_d = 1'b1;
    wr_ok   = bus.iCoeffWr && (state_q == S_IDLE) && ({1'b0, bus.iCoeffAddr} < NW'(NTAP));
    wdrop_d = bus.iCoeffWr && !wr_ok;
    busy_d  = (state_d != S_IDLE);
  end

  // Datapath: coefficient writes, delay line and per-lane select/multiply/accumulate.
  always_comb begin
    coef_d     = coef_q;
    dly_d      = dly_q;
    sel_coef_d = sel_coef_q;
    sel_dat_d  = sel_dat_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    for (int l = 0; l < int'(NUM_LANE); l++) begin
      for (int j = 0; j < int'(TAPS_PER_LANE); j++) begin
        if (wr_ok && (bus.iCoeffAddr == AW'(j * NUM_LANE + l))) coef_d[l][j] = bus.iCoeffData;
      end
    end
    if (accept) begin
      dly_d[0] = bus.iFirIn;
      for (int k = 1; k < int'(NTAP); k++) dly_d[k] = dly_q[k-1];
      for (int l = 0; l < int'(NUM_LANE); l++) begin
        sel_coef_d[l] = '0;
        sel_dat_d[l]  = '0;
        prod_d[l]     = '0;
        acc_d[l]      = '0;
      end
    end else if (state_q == S_MAC) begin
      for (int l = 0; l < int'(NUM_LANE); l++) begin
        sel_coef_d[l] = '0;
        sel_dat_d[l]  = '0;
        for (int j = 0; j < int'(TAPS_PER_LANE); j++) begin
          if ((cnt_q == CNT_W'(j)) && (NW'(j * NUM_LANE + l) < n_q)) begin
            sel_coef_d[l] = coef_q[l][j];
            sel_dat_d[l]  = dly_q[j * NUM_LANE + l];
          end
        end
        prod_d[l] = mul_ext(sel_coef_q[l], sel_dat_q[l]);
        acc_d[l]  = acc_q[l] + ACC_W'(prod_q[l]);
      end
    end
  end

  // Lane summation, scaling and output narrowing.
  always_comb begin
    sum_c = '0;
    for (int l = 0; l < int'(NUM_LANE); l++) sum_c = sum_c + acc_q[l];
    shift_c = sum_c >>> OUT_SHIFT;
`ifdef FIR_MAC_ARRAY_SAT_EN
    if (shift_c > SAT_MAX)      narrow_c = OUT_W'(SAT_MAX);
    else if (shift_c < SAT_MIN) narrow_c = OUT_W'(SAT_MIN);
    else                        narrow_c = OUT_W'(shift_c);
`else
    narrow_c = OUT_W'(shift_c);
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      coef_q     <= '{default: '0};
      dly_q      <= '{default: '0};
      sel_coef_q <= '{default: '0};
      sel_dat_q  <= '{default: '0};
      prod_q     <= '{default: '0};
      acc_q      <= '{default: '0};
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      sdrop_q    <= 1'b0;
      wdrop_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      coef_q     <= coef_d;
      dly_q      <= dly_d;
      sel_coef_q <= sel_coef_d;
      sel_dat_q  <= sel_dat_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      sdrop_q    <= sdrop_d;
      wdrop_q    <= wdrop_d;
    end
  end

  assign bus.oBusy       = busy_q;
  assign bus.oValid      = valid_q;
  assign bus.oFirOut     = out_q;
  assign bus.oSampleDrop = sdrop_q;
  assign bus.oWrDrop     = wdrop_q;
endmodule

// File: tb/tb_fir_mac_array.sv
// Scoreboard bench for fir_mac_array: stimulus pushes expected results,
// an independent monitor pops and compares on every DUT output event.
module tb_fir_mac_array;
  localparam int DATA_W = 3, COEF_W = 16, NUM_LANE = 4, TAPS_PER_LANE = 10;
  localparam int ACC_W = 25, OUT_W = 16, OUT_SHIFT = 0;
  localparam int NTAP = NUM_LANE * TAPS_PER_LANE;
  localparam int AW = $clog2(NTAP);
  localparam int NW = AW + 1;
  localparam int LAT = TAPS_PER_LANE + 5;
  localparam int OMAX = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN = -OMAX - 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_q[$];
  int   sdrop_q[$];
  int   wdrop_q[$];
  int   coef_m[NTAP];
  int   dly_m[NTAP];
  int   last_acc = 0;
  bit   have_last = 1'b0;

  fir_mac_array_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAP(NTAP), .OUT_W(OUT_W)) bus ();

  fir_mac_array #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_LANE(NUM_LANE), .TAPS_PER_LANE(TAPS_PER_LANE),
    .ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .iClk12M(clk),
    .iRst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Filter output from the tap equation: dot product, wrap, scale, narrow.
  function automatic int ref_out(input int n);
    longint s;
    logic signed [ACC_W-1:0] wrapped;
    logic signed [OUT_W-1:0] low;
    int r;
    s = 0;
    for (int k = 0; k < n; k++) s += longint'(coef_m[k]) * longint'(dly_m[k]);
    wrapped = ACC_W'(s);
    r = int'(wrapped >>> OUT_SHIFT);
`ifdef FIR_MAC_ARRAY_SAT_EN
    if (r > OMAX) r = OMAX;
    else if (r < OMIN) r = OMIN;
`else
    low = OUT_W'(r);
    r = int'(low);
`endif
    return r;
  endfunction

  // One input cycle; updates the reference model and expected-event queues.
  task automatic step(input bit en, input int x, input int nc, input bit wr, input int addr, input int data);
    int  c;
    bit  busy;
    int  n;
    exp_t e;
    @(negedge clk);
    c = cyc;
    rst = 1'b0;
    bus.iEnSample   = en;
    bus.iFirIn      = DATA_W'(x);
    bus.iNumOfCoeff = NW'(nc);
    bus.iCoeffWr    = wr;
    bus.iCoeffAddr  = AW'(addr);
    bus.iCoeffData  = COEF_W'(data);
    busy = have_last && (c >= last_acc + 1) && (c <= last_acc + LAT);
    if (wr) begin
      if (!busy && addr < NTAP) coef_m[addr] = data;
      else wdrop_q.push_back(c + 1);
    end
    if (en) begin
      if (busy) sdrop_q.push_back(c + 1);
      else begin
        for (int k = NTAP - 1; k > 0; k--) dly_m[k] = dly_m[k-1];
        dly_m[0] = x;
        n = (nc > NTAP) ? NTAP : nc;
        e.cyc = c + LAT;
        e.val = ref_out(n);
        exp_q.push_back(e);
        last_acc = c;
        have_last = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic sample(input int x, input int nc);
    step(1'b1, x, nc, 1'b0, 0, 0);
    idle(LAT);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.iEnSample = 1'b0; bus.iFirIn = '0; bus.iNumOfCoeff = '0;
    bus.iCoeffWr = 1'b0; bus.iCoeffAddr = '0; bus.iCoeffData = '0;
    exp_q.delete(); sdrop_q.delete(); wdrop_q.delete();
    for (int k = 0; k < NTAP; k++) begin coef_m[k] = 0; dly_m[k] = 0; end
    have_last = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 64'(bus.oBusy), 0);
    check("rst_valid", 64'(bus.oValid), 0);
    check("rst_fir_out", bus.oFirOut, 0);
    check("rst_sample_drop", 64'(bus.oSampleDrop), 0);
    check("rst_wr_drop", 64'(bus.oWrDrop), 0);
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    exp_t e;
    int   ec;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.oValid) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("fir_out", bus.oFirOut, e.val);
          check("valid_cycle", cyc, e.cyc);
        end else check("valid_cycle_unexpected", cyc, -1);
      end
      if (!rst && bus.oSampleDrop) begin
        ec = (sdrop_q.size() != 0) ? sdrop_q.pop_front() : -1;
        check("sample_drop_cycle", cyc, ec);
      end
      if (!rst && bus.oWrDrop) begin
        ec = (wdrop_q.size() != 0) ? wdrop_q.pop_front() : -1;
        check("wr_drop_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    do_reset();

    // Impulse response with coeff[k]=k+1, full tap count
    for (int k = 0; k < NTAP; k++) step(1'b0, 0, 0, 1'b1, k, k + 1);
    sample(1, 40);
    repeat (45) sample(0, 40);

    // Tap limit, zero taps, clamped tap count
    sample(1, 5);
    repeat (6) sample(0, 5);
    sample(1, 0);
    repeat (3) sample(0, 0);
    sample(1, 63);
    repeat (41) sample(0, 63);

    // Busy handshake: dropped strobe and dropped write
    step(1'b1, 3, 40, 1'b0, 0, 0);
    idle(2);
    step(1'b1, 2, 40, 1'b0, 0, 0);
    step(1'b0, 0, 0, 1'b1, 5, 999);
    idle(LAT - 4);
    sample(1, 40);
    repeat (8) sample(0, 40);

    // Same-cycle write and strobe; out-of-range write
    step(1'b0, 0, 0, 1'b1, 0, 0);
    step(1'b1, 2, 1, 1'b1, 0, 7);
    idle(LAT);
    step(1'b0, 0, 0, 1'b1, 40, 123);
    idle(2);
    sample(1, 1);

    // Saturation / wrap with all coefficients at full scale
    for (int k = 0; k < NTAP; k++) step(1'b0, 0, 0, 1'b1, k, 32767);
    repeat (40) sample(-4, 40);

    // Reset in the middle of MAC, then impulse with cleared coefficients
    step(1'b1, 1, 40, 1'b0, 0, 0);
    idle(4);
    do_reset();
    sample(1, 40);

    // Randomized traffic: writes, strobes with random gaps and tap counts
    for (int k = 0; k < NTAP; k++)
      step(1'b0, 0, 0, 1'b1, k, int'($urandom_range(0, 65535)) - 32768);
    repeat (150) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)
        step(1'b0, 0, 0, 1'b1, int'($urandom_range(0, 47)), int'($urandom_range(0, 65535)) - 32768);
      else if (r < 8) begin
        step(1'b1, int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 127)),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 47)), int'($urandom_range(0, 65535)) - 32768);
        idle(int'($urandom_range(0, 20)));
      end else idle(int'($urandom_range(1, 5)));
    end

    idle(LAT + 5);
    check("pending_outputs", exp_q.size(), 0);
    check("pending_sample_drops", sdrop_q.size(), 0);
    check("pending_wr_drops", wdrop_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
